// File: rtl/uart_note_sender_if.sv
// uart_note_sender_if: song-table read port of the note sender.
// Synchronous table: rom_note/rom_time follow rom_addr by one clock.
interface uart_note_sender_if;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_note;
    logic [15:0] rom_time;

    modport master (output rom_addr, input rom_note, input rom_time);
    modport slave  (input rom_addr, output rom_note, output rom_time);
endinterface

// File: rtl/uart_note_sender.sv
// uart_note_sender: plays a note/duration table out as 8N1 bytes with per-note holds.
// Define UART_NOTE_SYNC_EN to precede every sent byte with a 0xFF sync frame.
module uart_note_sender #(
    parameter int CLK_FREQ = 12000000,
    parameter int UART_BPS = 115200,
    parameter int TICK_DIV = 12000,
    parameter int SONG_LEN = 96
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    uart_note_sender_if.master rom,
    output logic               uart_txd,
    output logic               busy,
    output logic [7:0]         note_idx,
    output logic               done
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int BW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef UART_NOTE_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, SEND, HOLD} state_t;

    state_t          state, state_n;
    logic [7:0]      idx;
    logic [7:0]      shift;
    logic [7:0]      pend;
    logic            sync_ph;
    logic            rest;
    logic            stop_req;
    logic [BW-1:0]   baud_cnt;
    logic [3:0]      bit_cnt;
    logic [TW-1:0]   tick_cnt;
    logic [15:0]     ms_cnt;
    logic [15:0]     hold_ms;
    logic [2:0]      bsel;
    logic            go, stop_any, bit_end, frame_end;
    logic            hold_end, last, load_rest;

    assign go        = start & ~stop;
    assign stop_any  = stop_req | stop;
    assign bit_end   = baud_cnt == BW'(BPS_CNT - 1);
    assign frame_end = bit_end && (bit_cnt == 4'd9);
    assign hold_end  = (hold_ms == 16'd0) ||
                       ((tick_cnt == TW'(TICK_DIV - 1)) &&
                        (ms_cnt == hold_ms - 16'd1));
    assign last      = idx == 8'(SONG_LEN - 1);
    assign bsel      = bit_cnt[2:0] - 3'd1;

    // A stop abandons fetch/hold at once, but lets a note frame finish first.
    assign load_rest = stop_any &
                       ((state == FETCH) | (state == WAIT_ROM) |
                        (state == HOLD) |
                        ((state == SEND) & frame_end & ~sync_ph & ~rest));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (go) state_n = FETCH;
            FETCH:    state_n = load_rest ? SEND : WAIT_ROM;
            WAIT_ROM: state_n = SEND;
            SEND: begin
                if (frame_end) begin
                    if (sync_ph || load_rest) state_n = SEND;
                    else if (rest)            state_n = IDLE;
                    else                      state_n = HOLD;
                end
            end
            HOLD: begin
                if (load_rest)     state_n = SEND;
                else if (hold_end) state_n = (last && !loop_en) ? IDLE : FETCH;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy         = state != IDLE;
        rom.rom_addr = idx;
        uart_txd     = 1'b1;
        if (state == SEND) begin
            unique case (1'b1)
                bit_cnt == 4'd0: uart_txd = 1'b0;
                bit_cnt == 4'd9: uart_txd = 1'b1;
                default:         uart_txd = shift[bsel];
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx      <= '0;
            note_idx <= '0;
            shift    <= '0;
            pend     <= '0;
            sync_ph  <= 1'b0;
            rest     <= 1'b0;
            stop_req <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tick_cnt <= '0;
            ms_cnt   <= '0;
            hold_ms  <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state != IDLE) && (state_n == IDLE);
            if (state == IDLE) stop_req <= 1'b0;
            else if (stop)     stop_req <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        idx  <= '0;
                        rest <= 1'b0;
                    end
                end
                FETCH: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                WAIT_ROM: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!stop_any) begin
                        shift    <= SYNC_EN ? 8'hFF : rom.rom_note;
                        pend     <= rom.rom_note;
                        sync_ph  <= SYNC_EN;
                        hold_ms  <= rom.rom_time;
                        note_idx <= idx;
                    end
                end
                SEND: begin
                    baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
                    if (bit_end)
                        bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
                    if (frame_end) begin
                        tick_cnt <= '0;
                        ms_cnt   <= '0;
                        if (sync_ph) begin
                            shift   <= pend;
                            sync_ph <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (tick_cnt == TW'(TICK_DIV - 1)) begin
                        tick_cnt <= '0;
                        ms_cnt   <= ms_cnt + 16'd1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                    if (!stop_any && hold_end) begin
                        if (!last)        idx <= idx + 8'd1;
                        else if (loop_en) idx <= '0;
                    end
                end
                default: ;
            endcase
            if (load_rest) begin
                rest     <= 1'b1;
                shift    <= SYNC_EN ? 8'hFF : 8'h00;
                pend     <= 8'h00;
                sync_ph  <= SYNC_EN;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
        end
    end
endmodule
